// File: rtl/sar_search_ctrl_pkg.sv
// sar_search_ctrl_pkg: FSM state codes, comparator flag codes and a flag-validity helper
package sar_search_ctrl_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STEP   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] FLAG_G   = 3'b100;
    localparam logic [2:0] FLAG_E   = 3'b010;
    localparam logic [2:0] FLAG_L   = 3'b001;
    function automatic logic flags_ok(input logic [2:0] f);
        return f == FLAG_G || f == FLAG_E || f == FLAG_L;
    endfunction
endpackage

// File: rtl/sar_search_ctrl_if.sv
// sar_search_ctrl_if: search control/status and comparator flags; master is the search engine
interface sar_search_ctrl_if #(parameter int WIDTH = 4);
    logic             start;
    logic             cmp_g;
    logic             cmp_e;
    logic             cmp_l;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;
    modport master (input start, cmp_g, cmp_e, cmp_l, output trial, busy, done, result, err);
    modport slave  (output start, cmp_g, cmp_e, cmp_l, input trial, busy, done, result, err);
endinterface

// File: rtl/sar_settle_cnt.sv
// sar_settle_cnt: loadable down-counter that flags the last settle cycle of a trial
module sar_settle_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expire
);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign expire = cnt_q == '0;
endmodule

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: MSB-first successive-approximation search driven through a G/E/L comparator
module sar_search_ctrl
    import sar_search_ctrl_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CMP_WAIT = 0
) (
    input logic               clk,
    input logic               rst_n,
    sar_search_ctrl_if.master bus
);
    localparam int         IW     = $clog2(WIDTH);
    localparam logic [3:0] SETTLE = (CMP_WAIT == 0) ? 4'd0 : 4'(CMP_WAIT - 1);
    // with no settle time the first trial cycle is already the sampling cycle
    localparam logic [2:0] ENTRY  = (CMP_WAIT == 0) ? S_DECIDE : S_STEP;
    logic [2:0]       state_q, state_d, flags;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_n, trial_q, trial_d, result_q, result_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             accept, decide, finish, expire, load;
    sar_settle_cnt #(.CW(4)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (SETTLE),
        .expire   (expire)
    );
    always_comb begin
        flags    = {bus.cmp_g, bus.cmp_e, bus.cmp_l};
        acc_n    = (flags == FLAG_G) ? trial_q : acc_q;
        accept   = bus.start && (state_q == S_IDLE || state_q == S_DONE);
        decide   = state_q == S_DECIDE;
        finish   = decide && (!flags_ok(flags) || flags == FLAG_E || idx_q == '0);
        load     = accept || (decide && !finish);
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        trial_d  = trial_q;
        result_d = result_q;
        err_d    = err_q;
        if (accept) begin
            state_d = ENTRY;
            idx_d   = IW'(WIDTH - 1);
            acc_d   = '0;
            trial_d = {1'b1, {(WIDTH-1){1'b0}}};
            err_d   = 1'b0;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end else if (state_q == S_STEP || state_q == S_WAIT) begin
            state_d = expire ? S_DECIDE : S_WAIT;
        end else if (finish) begin
            state_d  = S_DONE;
            err_d    = !flags_ok(flags);
            result_d = !flags_ok(flags) ? acc_q : (flags == FLAG_E) ? trial_q : acc_n;
        end else if (decide) begin
            state_d = ENTRY;
            idx_d   = idx_q - IW'(1);
            acc_d   = acc_n;
            trial_d = acc_n | (WIDTH'(1) << (idx_q - IW'(1)));
        end
        busy_d = state_d inside {S_STEP, S_WAIT, S_DECIDE};
        done_d = state_d == S_DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            trial_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
    assign bus.trial  = trial_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: scoreboarded check of the SAR search engine at CMP_WAIT 0 and 3
module tb_sar_search_ctrl;
    logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, sel = 1'b0, frc_on = 1'b0;
    logic [3:0] a = '0, frc_trial = '0;
    int         n_tests = 0, n_fail = 0, cyc = 0;
    typedef struct {
        logic [3:0] res;
        logic       er;
        int         lat;
        int         cyc;
        logic [3:0] last;
    } exp_t;
    exp_t sb[$];
    exp_t e_mon;
    sar_search_ctrl_if #(.WIDTH(4)) b0 ();
    sar_search_ctrl_if #(.WIDTH(4)) b3 ();
    sar_search_ctrl #(.WIDTH(4), .CMP_WAIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    sar_search_ctrl #(.WIDTH(4), .CMP_WAIT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    assign b0.start = start & ~sel;
    assign b3.start = start & sel;
    assign {b0.cmp_g, b0.cmp_e, b0.cmp_l} = (frc_on && b0.trial == frc_trial) ? 3'b110 :
                                            {a > b0.trial, a == b0.trial, a < b0.trial};
    assign {b3.cmp_g, b3.cmp_e, b3.cmp_l} = (frc_on && b3.trial == frc_trial) ? 3'b110 :
                                            {a > b3.trial, a == b3.trial, a < b3.trial};
    logic [3:0] trial_m, result_m;
    logic       busy_m, done_m, err_m;
    assign trial_m  = sel ? b3.trial  : b0.trial;
    assign result_m = sel ? b3.result : b0.result;
    assign busy_m   = sel ? b3.busy   : b0.busy;
    assign done_m   = sel ? b3.done   : b0.done;
    assign err_m    = sel ? b3.err    : b0.err;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic void model(input logic [3:0] av, input int fstep, output logic [3:0][3:0] tr,
                                  output logic [3:0] res, output logic er, output int steps);
        logic [3:0] acc, t;
        logic [2:0] f;
        bit         fin;
        acc = '0; fin = 0; tr = '0; res = '0; er = 1'b0; steps = 0;
        for (int i = 3; i >= 0; i--) begin
            if (!fin) begin
                t = acc | (4'b0001 << i);
                tr[steps] = t;
                steps++;
                f = (steps == fstep) ? 3'b110 : {av > t, av == t, av < t};
                if (f == 3'b010) begin
                    res = t; fin = 1;
                end else if (f == 3'b100 || f == 3'b001) begin
                    if (f == 3'b100) acc = t;
                    if (i == 0) begin res = acc; fin = 1; end
                end else begin
                    er = 1'b1; res = acc; fin = 1;
                end
            end
        end
    endfunction
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst_n && done_m) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e_mon = sb.pop_front();
                chk("result", result_m, e_mon.res);
                chk("err", err_m, e_mon.er);
                chk("latency", cyc - e_mon.cyc, e_mon.lat);
                chk("trial_hold", trial_m, e_mon.last);
                chk("busy_at_done", busy_m, 0);
            end
        end
    end
    // returns at the negedge of the DONE cycle so a following call may chain a start into it
    task automatic search(input logic s3, input logic [3:0] av, input int fstep,
                          input bit poke, input bit nowait);
        logic [3:0][3:0] tr;
        logic [3:0]      res;
        logic            er;
        int              steps, w, k;
        bit              got;
        model(av, fstep, tr, res, er, steps);
        w = s3 ? 3 : 0;
        got = 0;
        if (!nowait) @(negedge clk);
        #1;
        sel = s3;
        a = av;
        frc_on = fstep != 0;
        frc_trial = (fstep != 0) ? tr[fstep - 1] : 4'd0;
        start = 1'b1;
        sb.push_back('{res, er, steps * (w + 1) + 1, cyc, tr[steps - 1]});
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (done_m) got = 1;
            else begin
                if (n == 1) begin
                    chk("busy_start", busy_m, 1);
                    chk("err_clr", err_m, 0);
                end
                k = (n - 1) / (w + 1);
                chk("trial", trial_m, tr[(k > 3) ? 3 : k]);
                #1 start = poke && n == 2;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_trial", b0.trial, 0);
        chk("rst_busy", b0.busy, 0);
        chk("rst_done", b0.done, 0);
        chk("rst_result", b0.result, 0);
        chk("rst_err", b0.err, 0);
        chk("rst_trial3", b3.trial, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        search(1'b0, 4'b1011, 0, 0, 0);
        search(1'b0, 4'b0000, 0, 0, 0);
        search(1'b0, 4'b1000, 0, 0, 0);
        search(1'b1, 4'b0111, 0, 0, 0);
        search(1'b1, 4'b1111, 0, 0, 0);
        search(1'b0, 4'b1011, 2, 0, 0);
        @(negedge clk);
        chk("err_sticky", err_m, 1);
        chk("result_held", result_m, 4'b1000);
        chk("done_one_cycle", done_m, 0);
        search(1'b0, 4'b0101, 0, 0, 0);
        search(1'b0, 4'b1000, 0, 0, 1);
        search(1'b0, 4'b0110, 0, 1, 1);
        search(1'b1, 4'b0010, 0, 1, 0);
        @(negedge clk);
        #1 sel = 1'b0; a = 4'b1101; frc_on = 1'b0; start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_trial", trial_m, 4'b1110);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_trial", b0.trial, 0);
        chk("arst_busy", b0.busy, 0);
        chk("arst_done", b0.done, 0);
        chk("arst_result", b0.result, 0);
        chk("arst_err", b0.err, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_done", b0.done, 0);
        end
        #1 rst_n = 1'b1;
        search(1'b0, 4'b1101, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
